// File: rtl/demo_pkg.sv
// Shared encodings for the demo traffic sequencer: run modes and FSM states.
package demo_pkg;

    localparam logic [1:0] RM_SINGLE = 2'd0;
    localparam logic [1:0] RM_BURST  = 2'd1;
    localparam logic [1:0] RM_CONT   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// registered one-cycle pulse when the debounced level falls (button pressed).
module btn_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic trigger
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          sync0;
    logic          sync1;
    logic          btn_db;
    logic [CW-1:0] cnt;

    // The debounced level only moves after DB_CYC consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            btn_db  <= 1'b1;
            cnt     <= '0;
            trigger <= 1'b0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            trigger <= 1'b0;
            if (sync1 != btn_db) begin
                if (cnt == CW'(DB_CYC - 1)) begin
                    btn_db  <= sync1;
                    cnt     <= '0;
                    trigger <= btn_db;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/demo_sequencer.sv
// Demo traffic controller: launches start pulses to the demo masters, tracks
// their ready handshakes and repeats as single shot, burst or continuous run.
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int CNT_W   = 8,
    parameter int DB_CYC  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_btn,
    input  logic [1:0]       run_mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             stop,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   ch_mode_in,
    input  logic [NCH-1:0]   ch_ready,
    output logic [NCH-1:0]   ch_start,
    output logic [NCH-1:0]   ch_mode,
    output logic             busy,
    output logic             done_pulse,
    output logic [CNT_W-1:0] done_cnt,
    output logic [NCH-1:0]   timeout_err
);

    localparam int TW = $clog2(TIMEOUT);

    state_t           state;
    logic             trigger;
    logic [NCH-1:0]   act;
    logic [NCH-1:0]   launched;
    logic [NCH-1:0]   seen_busy;
    logic [NCH-1:0]   cmpl;
    logic [1:0]       mode_r;
    logic [CNT_W:0]   len_r;
    logic [CNT_W:0]   iter;
    logic [TW-1:0]    tmo_cnt;
    logic             stop_req;

    logic [NCH-1:0]   launch_now;
    logic [NCH-1:0]   launched_nxt;
    logic [NCH-1:0]   seen_nxt;
    logic [NCH-1:0]   cmpl_nxt;
    logic             all_done;
    logic             tmo_hit;
    logic             last_iter;
    logic [CNT_W:0]   iter_nxt;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk     (clk),
        .rstn    (rstn),
        .btn     (start_btn),
        .trigger (trigger)
    );

    // A channel only counts as complete after ready has gone low following its
    // start and come back high; ready still high right after start is ignored.
    always_comb begin
        launch_now   = act & ~launched & ch_ready;
        launched_nxt = launched | launch_now;
        seen_nxt     = seen_busy | (launched & ~ch_ready);
        cmpl_nxt     = cmpl | (launched & seen_busy & ch_ready);
        all_done     = ((cmpl_nxt & act) == act);
        tmo_hit      = (tmo_cnt == TW'(TIMEOUT - 1));
        iter_nxt     = iter + 1'b1;
        case (mode_r)
            RM_BURST: last_iter = (iter_nxt == len_r);
            RM_CONT:  last_iter = 1'b0;
            default:  last_iter = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            act         <= '0;
            launched    <= '0;
            seen_busy   <= '0;
            cmpl        <= '0;
            mode_r      <= RM_SINGLE;
            len_r       <= '0;
            iter        <= '0;
            tmo_cnt     <= '0;
            stop_req    <= 1'b0;
            ch_start    <= '0;
            ch_mode     <= '0;
            busy        <= 1'b0;
            done_pulse  <= 1'b0;
            done_cnt    <= '0;
            timeout_err <= '0;
        end else begin
            ch_start   <= '0;
            done_pulse <= 1'b0;
            if (busy)
                stop_req <= stop_req | stop;
            case (state)
                S_IDLE: begin
                    if (trigger && |ch_en) begin
                        act         <= ch_en;
                        ch_mode     <= ch_mode_in;
                        mode_r      <= run_mode;
                        len_r       <= (burst_len == '0) ? (CNT_W+1)'(1) : {1'b0, burst_len};
                        done_cnt    <= '0;
                        timeout_err <= '0;
                        stop_req    <= 1'b0;
                        iter        <= '0;
                        launched    <= '0;
                        seen_busy   <= '0;
                        cmpl        <= '0;
                        tmo_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH, S_WAIT: begin
                    tmo_cnt   <= tmo_cnt + 1'b1;
                    seen_busy <= seen_nxt;
                    cmpl      <= cmpl_nxt;
                    if (state == S_LAUNCH) begin
                        ch_start <= launch_now;
                        launched <= launched_nxt;
                    end
                    // Completion is checked before the timeout so it wins a tie.
                    if (state == S_WAIT && all_done) begin
                        iter     <= iter_nxt;
                        done_cnt <= done_cnt + 1'b1;
                        if (last_iter || stop_req || stop) begin
                            done_pulse <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            launched  <= '0;
                            seen_busy <= '0;
                            cmpl      <= '0;
                            tmo_cnt   <= '0;
                            state     <= S_LAUNCH;
                        end
                    end else if (tmo_hit) begin
                        ch_start    <= '0;
                        timeout_err <= act & ~cmpl_nxt;
                        done_pulse  <= 1'b1;
                        state       <= S_DONE;
                    end else if (state == S_LAUNCH && launched_nxt == act) begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
